// File: rtl/match_monitor.sv
// match_monitor: rising-edge match detector with counters, gap timer,
// retriggerable stretch indicator and a sticky burst alarm FSM.
module match_monitor #(
  parameter int WINDOW  = 16,
  parameter int BURST   = 3,
  parameter int STRETCH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       match_in,
  input  logic       clr,
  output logic       match_pulse,
  output logic [7:0] match_count,
  output logic [7:0] gap_cycles,
  output logic       gap_valid,
  output logic       stretch_out,
  output logic       burst_alarm,
  output logic [1:0] mon_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    ALARM = 2'd2
  } state_t;

  localparam logic [7:0] WIN_INIT = 8'(WINDOW - 1);
  localparam logic [3:0] BURST_N  = 4'(BURST);
  localparam logic [7:0] STR_INIT = 8'(STRETCH);

  logic       prev_q;
  logic       rise;
  logic       hit;
  logic [7:0] gap_cnt;
  logic [7:0] str_cnt;
  logic [7:0] win_q;
  logic [7:0] win_d;
  logic [3:0] bc_q;
  logic [3:0] bc_d;
  state_t     state_q;
  state_t     state_d;

  // rise drives the pulse and stretch; hit (rise without clr) drives counters
  assign rise = ena & match_in & ~prev_q;
  assign hit  = rise & ~clr;

  assign stretch_out = (str_cnt != 8'd0);
  assign burst_alarm = (state_q == ALARM);
  assign mon_state   = state_q;

  // Prior-value register and registered one-cycle match pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q      <= 1'b0;
      match_pulse <= 1'b0;
    end else begin
      match_pulse <= rise;
      if (ena) prev_q <= match_in;
    end
  end

  // Saturating match counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_count <= 8'd0;
    end else if (ena) begin
      if (clr)
        match_count <= 8'd0;
      else if (hit && match_count != 8'hff)
        match_count <= match_count + 8'd1;
    end
  end

  // Gap timer: zero means no match seen yet since reset/clr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_cnt    <= 8'd0;
      gap_cycles <= 8'd0;
      gap_valid  <= 1'b0;
    end else if (ena) begin
      if (clr) begin
        gap_cnt    <= 8'd0;
        gap_cycles <= 8'd0;
        gap_valid  <= 1'b0;
      end else if (hit) begin
        gap_cnt <= 8'd1;
        if (gap_cnt != 8'd0) begin
          gap_cycles <= gap_cnt;
          gap_valid  <= 1'b1;
        end
      end else if (gap_cnt != 8'd0 && gap_cnt != 8'hff) begin
        gap_cnt <= gap_cnt + 8'd1;
      end
    end
  end

  // Retriggerable stretch counter, unaffected by clr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      str_cnt <= 8'd0;
    end else if (ena) begin
      if (rise)
        str_cnt <= STR_INIT;
      else if (str_cnt != 8'd0)
        str_cnt <= str_cnt - 8'd1;
    end
  end

  // Burst FSM state, window and burst counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= 8'd0;
      bc_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      bc_q    <= bc_d;
    end
  end

  // Burst FSM next state; a match at window expiry still counts
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    bc_d    = bc_q;
    if (ena) begin
      if (clr) begin
        state_d = IDLE;
        win_d   = 8'd0;
        bc_d    = 4'd0;
      end else begin
        case (state_q)
          IDLE: begin
            if (hit) begin
              state_d = ARMED;
              win_d   = WIN_INIT;
              bc_d    = 4'd1;
            end
          end
          ARMED: begin
            if (hit) begin
              bc_d  = bc_q + 4'd1;
              win_d = (win_q != 8'd0) ? win_q - 8'd1 : 8'd0;
              if (bc_d == BURST_N) state_d = ALARM;
            end else if (win_q == 8'd0) begin
              state_d = IDLE;
              bc_d    = 4'd0;
            end else begin
              win_d = win_q - 8'd1;
            end
          end
          ALARM: begin
            state_d = ALARM;
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/match_monitor.md
MATCH_MONITOR -- requirements
Module: match_monitor

Interface
REQ-001 SHALL have parameter WINDOW, default 16, burst window length in clock cycles (range 2..255).
REQ-002 SHALL have parameter BURST, default 3, number of matches inside one window that raises the alarm (range 2..15).
REQ-003 SHALL have parameter STRETCH, default 8, length of the stretched indicator in cycles (range 1..255).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port ena  input  1  clock enable; when 0, all state holds.
REQ-007 SHALL have port match_in  input  1  detector output_indicator level, synchronous to clk, may stay high for several cycles.
REQ-008 SHALL have port clr  input  1  synchronous clear of counters and alarm.
REQ-009 SHALL have port match_pulse  output  1  one-cycle pulse per detected match.
REQ-010 SHALL have port match_count  output  8  number of matches since reset or clr, saturating.
REQ-011 SHALL have port gap_cycles  output  8  cycles between the last two matches, saturating.
REQ-012 SHALL have port gap_valid  output  1  high once gap_cycles holds a measured gap.
REQ-013 SHALL have port stretch_out  output  1  retriggerable STRETCH-cycle indicator.
REQ-014 SHALL have port burst_alarm  output  1  sticky burst alarm.
REQ-015 SHALL have port mon_state  output  2  burst FSM state: IDLE=0, ARMED=1, ALARM=2.

Function
REQ-016 SHALL register match_in in a prior-value register and assert match_pulse for exactly one cycle when ena=1, match_in=1 and the prior value=0 (rising edge).
REQ-017 SHALL register match_pulse; it is asserted in the cycle after the clk edge at which the rising edge is sampled.
REQ-018 SHALL hold the prior-value register, all counters and the FSM when ena=0, and force match_pulse to 0.
REQ-019 SHALL increment match_count on each match_pulse and saturate at 255 with no wrap.
REQ-020 SHALL run an 8-bit gap counter that loads 1 on a match and increments by 1 on every subsequent ena=1 cycle, saturating at 255.
REQ-021 SHALL load gap_cycles with the gap counter value on every match except the first after reset or clr.
REQ-022 SHALL set gap_valid on that second match and keep it set until reset or clr.
REQ-023 SHALL load the stretch counter with STRETCH on each match.
REQ-024 SHALL decrement the stretch counter by 1 on each ena=1 cycle, stopping at 0.
REQ-025 SHALL drive stretch_out = (stretch counter != 0); a new match while the counter is nonzero reloads it.
REQ-026 SHALL implement the burst FSM with the following transitions:
- IDLE --match--> ARMED, with window counter = WINDOW-1 and burst count = 1.
- ARMED --match--> burst count + 1; if the new count equals BURST, go to ALARM.
- ARMED, window counter = 0 with no match in that cycle --> IDLE.
- ARMED, otherwise --> window counter - 1.
- ALARM --> holds until clr or rst.
REQ-027 SHALL count a match that coincides with window expiry toward the current window.
REQ-028 SHALL drive burst_alarm = (state == ALARM).
REQ-029 SHALL respond to clr=1 (when ena=1) as follows:
- zero match_count, gap counter, gap_cycles, gap_valid, burst count and window counter;
- force IDLE;
- leave the stretch counter and the prior-value register updating normally.
REQ-030 SHALL give clr priority over a simultaneous match; that match is discarded from all counters, but match_pulse still fires and the stretch counter reloads.

Reset
REQ-031 SHALL, while rst=1 (asynchronous), clear every register: all outputs 0, mon_state=IDLE, prior-value register 0.
REQ-032 SHALL abandon any window or stretch in progress when reset is asserted mid-operation; after release, a match_in already high is counted as a new rising edge.

Verification
REQ-033 Bench SHALL cover: match_in held high 5 cycles, ena=1 -> match_pulse is high for exactly 1 cycle, match_count=1, stretch_out is high for 8 cycles.
REQ-034 Bench SHALL cover: matches at cycles 0, 6, 9 -> gap_cycles = 6 after the second match and 3 after the third; gap_valid rises at the second match.
REQ-035 Bench SHALL cover: 3 matches within 16 cycles -> mon_state goes 1 then 2, and burst_alarm stays 1 through 40 idle cycles until clr.
REQ-036 Bench SHALL cover: 2 matches, then 20 idle cycles, then 1 match -> FSM returns to IDLE, then ARMED; no alarm.
REQ-037 Bench SHALL cover: 300 isolated matches -> match_count=255; gap of 300 idle cycles -> gap_cycles=255.
REQ-038 Bench SHALL cover: ena=0 during a rising match_in, and rst asserted mid-window -> no pulse and no count under ena=0; all outputs 0 immediately on rst without waiting for a clock edge.
